// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with redirect, stall handshake and HALT detection.
// Optional one-entry prefetch buffer enabled by defining FETCH_BUF_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        valid,
    output logic [15:0] instr,
    output logic [4:0]  instr1,
    output logic [1:0]  instr2,
    output logic [15:0] pc_plus2,
    output logic        halted
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic        consume;
    logic        fire;
    logic        is_halt;
`ifdef FETCH_BUF_EN
    logic        buf_valid;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc2;
    // keep fetching into the buffer while decode stalls, until it fills
    assign imem_req = (state == FETCH) && !redirect && (!valid || !stall || !buf_valid);
`else
    assign imem_req = (state == FETCH) && !redirect && (!valid || !stall);
`endif
    assign consume   = valid && !stall;
    assign fire      = imem_req && imem_rdy;
    assign is_halt   = imem_data[15:11] == 5'b00000;
    assign imem_addr = pc;
    assign halted    = state == HALT;
    assign instr1    = instr[15:11];
    assign instr2    = instr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= 16'h0000;
            instr    <= 16'h0000;
            pc_plus2 <= 16'h0000;
            valid    <= 1'b0;
`ifdef FETCH_BUF_EN
            buf_valid <= 1'b0;
            buf_instr <= 16'h0000;
            buf_pc2   <= 16'h0000;
`endif
        end else if (state == IDLE) begin
            state <= FETCH;
            if (redirect)
                pc <= redirect_pc;
        end else if (state == FETCH && redirect) begin
            pc    <= redirect_pc;
            valid <= 1'b0;
`ifdef FETCH_BUF_EN
            buf_valid <= 1'b0;
`endif
        end else begin
            if (fire) begin
                pc <= pc + 16'd2;
                if (is_halt)
                    state <= HALT;
            end
`ifdef FETCH_BUF_EN
            if (consume) begin
                if (buf_valid) begin
                    instr     <= buf_instr;
                    pc_plus2  <= buf_pc2;
                    buf_valid <= 1'b0;
                end else if (!fire) begin
                    valid <= 1'b0;
                end
            end
            // new data goes straight to the slot only if nothing older is waiting
            if (fire) begin
                if (!valid || (consume && !buf_valid)) begin
                    instr    <= imem_data;
                    pc_plus2 <= pc + 16'd2;
                    valid    <= 1'b1;
                end else begin
                    buf_instr <= imem_data;
                    buf_pc2   <= pc + 16'd2;
                    buf_valid <= 1'b1;
                end
            end
`else
            if (fire) begin
                instr    <= imem_data;
                pc_plus2 <= pc + 16'd2;
                valid    <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        valid;
    logic [15:0] instr;
    logic [4:0]  instr1;
    logic [1:0]  instr2;
    logic [15:0] pc_plus2;
    logic        halted;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .valid(valid), .instr(instr),
        .instr1(instr1), .instr2(instr2), .pc_plus2(pc_plus2), .halted(halted)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 fetching, 2 halted; queue of presented/buffered instructions
    int          m_st;
    logic [15:0] m_pc;
    logic [15:0] qi[$];
    logic [15:0] qp[$];

    function automatic bit m_req();
        return m_st == 1 && !redirect &&
               (qi.size() == 0 || !stall || qi.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0;
            m_pc = 16'h0;
            qi.delete();
            qp.delete();
        end else if (m_st == 0) begin
            if (redirect) m_pc = redirect_pc;
            m_st = 1;
        end else if (m_st == 1 && redirect) begin
            m_pc = redirect_pc;
            qi.delete();
            qp.delete();
        end else begin
            bit r;
            bit c;
            r = m_req();
            c = qi.size() > 0 && !stall;
            if (c) begin
                void'(qi.pop_front());
                void'(qp.pop_front());
            end
            if (r && imem_rdy) begin
                qi.push_back(imem_data);
                qp.push_back(m_pc + 16'd2);
                m_pc = m_pc + 16'd2;
                if (imem_data[15:11] == 5'd0) m_st = 2;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req", {31'd0, imem_req}, {31'd0, m_req()});
        chk("addr", {16'd0, imem_addr}, {16'd0, m_pc});
        chk("valid", {31'd0, valid}, {31'd0, qi.size() > 0});
        chk("halted", {31'd0, halted}, {31'd0, m_st == 2});
        if (qi.size() > 0) begin
            chk("instr", {16'd0, instr}, {16'd0, qi[0]});
            chk("pc_plus2", {16'd0, pc_plus2}, {16'd0, qp[0]});
            chk("instr1", {27'd0, instr1}, {27'd0, qi[0][15:11]});
            chk("instr2", {30'd0, instr2}, {30'd0, qi[0][1:0]});
        end
    end

    task automatic step(input logic rdy, input logic [15:0] d, input logic rd,
                        input logic [15:0] rp, input logic st);
        imem_rdy = rdy;
        imem_data = d;
        redirect = rd;
        redirect_pc = rp;
        stall = st;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'h0);
        chk("rst_pc2", {16'd0, pc_plus2}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step(0, 16'h0, 0, 16'h0, 0);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {16'd0, imem_addr}, 32'h0000);
        step(1, 16'h4001, 0, 16'h0, 0);
        chk("sl_instr1_a", {27'd0, instr1}, 32'b01000);
        chk("sl_pc2_a", {16'd0, pc_plus2}, 32'h0002);
        chk("sl_addr_a", {16'd0, imem_addr}, 32'h0002);
        step(1, 16'h4802, 0, 16'h0, 0);
        chk("sl_instr1_b", {27'd0, instr1}, 32'b01001);
        chk("sl_pc2_b", {16'd0, pc_plus2}, 32'h0004);
        chk("sl_addr_b", {16'd0, imem_addr}, 32'h0004);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h5003, 0, 16'h0, 1);
`ifndef FETCH_BUF_EN
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr", {16'd0, instr}, 32'h4802);
            chk("stall_pc2", {16'd0, pc_plus2}, 32'h0004);
`endif
        end
        step(1, 16'h5003, 0, 16'h0, 0);
`ifndef FETCH_BUF_EN
        chk("resume_instr", {16'd0, instr}, 32'h5003);
        chk("resume_pc2", {16'd0, pc_plus2}, 32'h0006);
`endif
        step(1, 16'hD801, 1, 16'h0100, 0);
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("redir_addr", {16'd0, imem_addr}, 32'h0100);
        step(1, 16'h6005, 0, 16'h0, 0);
        chk("redir_instr", {16'd0, instr}, 32'h6005);
        chk("redir_pc2", {16'd0, pc_plus2}, 32'h0102);
        step(0, 16'h0, 1, 16'hFFFE, 0);
        step(1, 16'h7006, 0, 16'h0, 0);
        chk("wrap_pc2", {16'd0, pc_plus2}, 32'h0000);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        chk("wrap_instr2", {30'd0, instr2}, 32'b10);
        step(0, 16'h0, 1, 16'h0201, 0);
        step(1, 16'h3000, 0, 16'h0, 0);
        chk("odd_pc2", {16'd0, pc_plus2}, 32'h0203);
        imem_rdy = 1'b0;
        stall = 1'b1;
        #1 rst = 1'b1;
        imem_rdy = 1'b1;
        imem_data = 16'h4001;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", {16'd0, imem_addr}, 32'h0000);
        chk("arst_instr", {16'd0, instr}, 32'h0000);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("arst_late_rdy", {31'd0, valid}, 32'd0);
        step(1, 16'h4001, 0, 16'h0, 0);
        chk("arst_instr2", {16'd0, instr}, 32'h4001);
        chk("arst_pc2", {16'd0, pc_plus2}, 32'h0002);
        step(0, 16'h0, 0, 16'h0, 0);
        step(1, 16'h0000, 0, 16'h0, 1);
        chk("halt_valid", {31'd0, valid}, 32'd1);
        chk("halt_instr1", {27'd0, instr1}, 32'b00000);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_addr", {16'd0, imem_addr}, 32'h0004);
        for (int i = 0; i < 2; i++) begin
            step(1, 16'h4001, 1, 16'h1234, 1);
            chk("halt_frozen_addr", {16'd0, imem_addr}, 32'h0004);
            chk("halt_frozen_valid", {31'd0, valid}, 32'd1);
        end
        step(1, 16'h4001, 0, 16'h0, 1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        step(0, 16'h0, 0, 16'h0, 0);
        chk("halt_consumed", {31'd0, valid}, 32'd0);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        step(1, 16'h4001, 1, 16'h2000, 0);
        step(0, 16'h0, 0, 16'h0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
